ahb_sram_ws: RTL



---
 rtl/ahb_sram_ws_if.sv | 25 ++
 rtl/ahb_sram_ws.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ws_if.sv
// AHB-Lite bus bundle between the decoder/mux (master side) and the SRAM slave.
// HREADY is the mux-level ready fed back to every slave, so it sits on the
// master side of the bundle.
interface ahb_sram_ws_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave with a synchronous read port, programmable data-phase
// wait states, a two-cycle ERROR response for illegal size/alignment and
// read-after-write forwarding for pipelined write->read to the same word.
// LED mirrors byte 0 of word 0 whenever that byte is written.
module ahb_sram_ws #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       MEM_INIT    = ""
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_sram_ws_if.slave       ahb,
  output logic [7:0]         LED
);

  localparam int unsigned IW    = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IW;
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [2:0]  WS_LOAD  = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [2:0]  cnt;
  logic        ready_q;
  logic        resp_q;

  logic        accept;
  logic        illegal;
  logic [IW-1:0] a_idx;

  logic        dp_valid;
  logic        dp_write;
  logic [IW-1:0] dp_idx;
  logic [1:0]  dp_off;
  logic [1:0]  dp_size;
  logic [3:0]  dp_lanes;

  logic        wr_commit;
  logic        reissue;

  logic [31:0] ram_q;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  logic [31:0] rdata;

  logic        unused_bits;

  assign accept  = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign illegal = (ahb.HSIZE > 3'd2)
                 | ((ahb.HSIZE == 3'd1) & ahb.HADDR[0])
                 | ((ahb.HSIZE == 3'd2) & (ahb.HADDR[1:0] != 2'b00));
  assign a_idx   = ahb.HADDR[ADDR_WIDTH-1:2];

  // A write data phase finishes on the edge where we present ready.
  assign wr_commit = ready_q & dp_valid & dp_write;

  // Last wait cycle of a read: fetch again so writes committed since the
  // address phase are visible.
  assign reissue = (state == ST_WAIT) & (cnt == 3'd0) & dp_valid & ~dp_write;

  assign unused_bits = ^{ahb.HTRANS[0], ahb.HADDR[31:ADDR_WIDTH]};

  // Response FSM: wait-state countdown and two-cycle error, registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept && illegal) begin
            state   <= ST_ERR1;
            ready_q <= 1'b0;
            resp_q  <= 1'b1;
          end else if (accept && HAS_WAIT) begin
            state   <= ST_WAIT;
            cnt     <= WS_LOAD;
            ready_q <= 1'b0;
            resp_q  <= 1'b0;
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd0) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  // Capture the address phase; an errored transfer leaves no live data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_off   <= '0;
      dp_size  <= '0;
    end else if (accept) begin
      dp_valid <= ~illegal;
      dp_write <= ahb.HWRITE;
      dp_idx   <= a_idx;
      dp_off   <= ahb.HADDR[1:0];
      dp_size  <= ahb.HSIZE[1:0];
    end else if (ready_q) begin
      dp_valid <= 1'b0;
    end
  end

  // Byte-lane enables of the current data phase.
  always_comb begin
    dp_lanes = 4'b0000;
    if (dp_valid) begin
      case (dp_size)
        2'd0:    dp_lanes = 4'b0001 << dp_off;
        2'd1:    dp_lanes = dp_off[1] ? 4'b1100 : 4'b0011;
        2'd2:    dp_lanes = 4'b1111;
        default: dp_lanes = 4'b0000;
      endcase
    end
  end

  // RAM write port: commit enabled lanes at the end of a write data phase.
  always_ff @(posedge HCLK) begin
    if (wr_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (dp_lanes[i]) begin
          mem[dp_idx][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
        end
      end
    end
  end

  // RAM read port plus forwarding capture. The RAM returns pre-write data
  // when a read is accepted on the same edge a write to that word commits,
  // so the committing lanes are latched alongside and merged on the way out.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ram_q    <= '0;
      fwd_mask <= '0;
      fwd_data <= '0;
    end else if (reissue) begin
      ram_q    <= mem[dp_idx];
      fwd_mask <= '0;
    end else if (accept && !ahb.HWRITE && !illegal) begin
      ram_q    <= mem[a_idx];
      fwd_mask <= (wr_commit && (dp_idx == a_idx)) ? dp_lanes : 4'b0000;
      fwd_data <= ahb.HWDATA;
    end
  end

  // Read data: RAM word with forwarded lanes substituted; holds between reads.
  always_comb begin
    rdata = ram_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (fwd_mask[i]) begin
        rdata[8*i +: 8] = fwd_data[8*i +: 8];
      end
    end
  end

  // Diagnostic LED shadow of word 0, byte 0.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      LED <= '0;
    end else if (wr_commit && (dp_idx == '0) && dp_lanes[0]) begin
      LED <= ahb.HWDATA[7:0];
    end
  end

  assign ahb.HREADYOUT = ready_q;
  assign ahb.HRESP     = resp_q;
  assign ahb.HRDATA    = rdata;

endmodule
